// File: rtl/tinyalu_pkg.sv
// Shared types for the tiny ALU: operation codes, controller states and the
// single-cycle datapath function.
package tinyalu_pkg;

  localparam int MUL_LAT_DEFAULT = 3;

  typedef enum logic [2:0] {
    NO_OP  = 3'b000,
    ADD_OP = 3'b001,
    AND_OP = 3'b010,
    XOR_OP = 3'b011,
    MUL_OP = 3'b100,
    RST_OP = 3'b111
  } operation_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  // The add keeps its carry, so the sum is 9 bits wide before zero extension.
  function automatic logic [15:0] alu_result(operation_t op, logic [7:0] a, logic [7:0] b);
    logic [15:0] res;
    res = 16'h0000;
    case (op)
      ADD_OP:  res = {7'b0, ({1'b0, a} + {1'b0, b})};
      AND_OP:  res = {8'b0, (a & b)};
      XOR_OP:  res = {8'b0, (a ^ b)};
      default: res = 16'h0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tinyalu_if.sv
// Command/response bus between an initiator and the tiny ALU core.
interface tinyalu_if;
  import tinyalu_pkg::*;

  logic        start;
  logic [2:0]  op;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        done;
  logic [15:0] result;
  logic        err;

  modport master (output start, op, A, B, input done, result, err);
  modport slave  (input start, op, A, B, output done, result, err);

endinterface

// File: rtl/tinyalu_mul_pipe.sv
// Pipelined 8x8 unsigned multiplier with a valid bit travelling alongside.
module tinyalu_mul_pipe #(
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        valid_out,
  output logic [15:0] product
);

  logic [LAT-1:0] valid_q, valid_d;
  logic [15:0]    prod_q [LAT];
  logic [15:0]    prod_d [LAT];

  always_comb begin
    valid_d   = {valid_q[LAT-2:0], valid_in};
    prod_d[0] = 16'(a) * 16'(b);
    for (int i = 1; i < LAT; i++) begin
      prod_d[i] = prod_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        prod_q[i] <= 16'h0000;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < LAT; i++) begin
        prod_q[i] <= prod_d[i];
      end
    end
  end

  assign valid_out = valid_q[LAT-1];
  assign product   = prod_q[LAT-1];

endmodule

// File: rtl/tinyalu_core.sv
// Tiny ALU controller: accepts one command per start assertion, answers with a
// single done (or err) pulse and waits for start to drop before re-arming.
module tinyalu_core
  import tinyalu_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic     clk,
  input  logic     reset,
  tinyalu_if.slave bus
);

  state_t      state_q, state_d;
  operation_t  op_q, op_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] result_q, result_d;

  logic        mul_valid_in;
  logic        mul_valid_out;
  logic [15:0] mul_product;

  // The pipe captures the live operands on the accepting edge, so that edge is
  // its first stage and the output register here adds the last cycle.
  tinyalu_mul_pipe #(
    .LAT (MUL_LAT)
  ) u_mul_pipe (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (mul_valid_in),
    .a         (bus.A),
    .b         (bus.B),
    .valid_out (mul_valid_out),
    .product   (mul_product)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    result_d     = result_q;
    mul_valid_in = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (operation_t'(bus.op))
            NO_OP: ;
            RST_OP: result_d = 16'h0000;
            ADD_OP, AND_OP, XOR_OP: begin
              op_d    = operation_t'(bus.op);
              a_d     = bus.A;
              b_d     = bus.B;
              state_d = BUSY;
            end
            MUL_OP: begin
              op_d         = MUL_OP;
              a_d          = bus.A;
              b_d          = bus.B;
              mul_valid_in = 1'b1;
              state_d      = BUSY;
            end
            default: begin
              err_d   = 1'b1;
              state_d = WAIT_LOW;
            end
          endcase
        end
      end

      BUSY: begin
        if (op_q == MUL_OP) begin
          if (mul_valid_out) begin
            result_d = mul_product;
            done_d   = 1'b1;
            state_d  = WAIT_LOW;
          end
        end else begin
          result_d = alu_result(op_q, a_q, b_q);
          done_d   = 1'b1;
          state_d  = WAIT_LOW;
        end
      end

      // Start may still be held for the command just finished; only its
      // release re-arms the controller.
      WAIT_LOW: begin
        if (!bus.start) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= NO_OP;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_tinyalu_core.sv
// Directed bench for tinyalu_core: stimulus tasks schedule the responses the
// protocol demands, and a per-cycle checker compares the DUT against them.
module tb_tinyalu_core;
  import tinyalu_pkg::*;

  localparam int MUL_LAT = 3;
  localparam int EV_DONE = 0;
  localparam int EV_ERR  = 1;
  localparam int EV_CLR  = 2;
  localparam int EV_RST  = 3;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
  } ev_t;

  logic clk;
  logic reset;
  int   cyc;
  int   vectors;
  int   miscompares;
  int   done_seen;
  logic [15:0] exp_result;
  ev_t  evq[$];

  tinyalu_if bus ();

  tinyalu_core #(
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [15:0] model_value(logic [2:0] op_code, logic [7:0] a, logic [7:0] b);
    int r;
    r = 0;
    case (op_code)
      3'b001: r = int'(a) + int'(b);
      3'b010: r = int'(a & b);
      3'b011: r = int'(a ^ b);
      3'b100: r = int'(a) * int'(b);
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  function automatic void schedule(int at, int kind, logic [15:0] val);
    ev_t e;
    e.cyc  = at;
    e.kind = kind;
    e.val  = val;
    evq.push_back(e);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Per-cycle checker: applies the events due this cycle, then compares.
  always @(negedge clk) begin
    logic exp_done;
    logic exp_err;
    bit   rst_hit;
    if (cyc >= 1) begin
      exp_done = 1'b0;
      exp_err  = 1'b0;
      rst_hit  = 1'b0;
      foreach (evq[i]) if (evq[i].cyc == cyc && evq[i].kind == EV_RST) rst_hit = 1'b1;
      if (rst_hit) begin
        exp_result = 16'h0000;
      end else begin
        foreach (evq[i]) begin
          if (evq[i].cyc == cyc) begin
            case (evq[i].kind)
              EV_DONE: begin exp_done = 1'b1; exp_result = evq[i].val; end
              EV_ERR:  exp_err = 1'b1;
              EV_CLR:  exp_result = 16'h0000;
              default: ;
            endcase
          end
        end
      end
      for (int i = evq.size() - 1; i >= 0; i--) begin
        if (rst_hit || evq[i].cyc <= cyc) evq.delete(i);
      end
      if (bus.done === 1'b1) done_seen++;
      checkOutput($sformatf("done@%0d", cyc), int'(bus.done), int'(exp_done));
      checkOutput($sformatf("err@%0d", cyc), int'(bus.err), int'(exp_err));
      checkOutput($sformatf("result@%0d", cyc), int'(bus.result), int'(exp_result));
    end
  end

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Issues one command from a negedge; returns at a negedge with the DUT idle.
  task automatic applyStimulus(input logic [2:0] op_code, input logic [7:0] a, input logic [7:0] b,
                               input int hold_extra, input bit drop_early, input bit scramble);
    int k;
    int lat;
    k = cyc + 1;
    bus.start = 1'b1;
    bus.op    = op_code;
    bus.A     = a;
    bus.B     = b;
    lat = 0;
    case (op_code)
      3'b001, 3'b010, 3'b011: lat = 1;
      3'b100:  lat = MUL_LAT;
      3'b111:  schedule(k, EV_CLR, 16'h0000);
      3'b000:  ;
      default: schedule(k, EV_ERR, 16'h0000);
    endcase
    if (lat > 0) begin
      schedule(k + lat, EV_DONE, model_value(op_code, a, b));
      wait_until(k);
      if (scramble) begin
        bus.A = 8'h00;
        bus.B = 8'h00;
      end
      if (drop_early) bus.start = 1'b0;
      wait_until(k + lat);
      repeat (hold_extra) @(negedge clk);
    end else begin
      wait_until(k);
    end
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int d0;
    vectors     = 0;
    miscompares = 0;
    done_seen   = 0;
    exp_result  = 16'h0000;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 3'b000;
    bus.A       = 8'h00;
    bus.B       = 8'h00;
    schedule(1, EV_RST, 16'h0000);
    schedule(2, EV_RST, 16'h0000);
    repeat (2) @(negedge clk);
    checkOutput("reset_result", int'(bus.result), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    checkOutput("reset_err", int'(bus.err), 0);
    reset = 1'b0;

    $display("[TB] add 0xFF+0xFF");
    d0 = done_seen;
    applyStimulus(3'b001, 8'hFF, 8'hFF, 0, 1'b0, 1'b0);
    checkOutput("add_ff_result", int'(bus.result), 'h01FE);
    checkOutput("add_ff_pulses", done_seen - d0, 1);

    $display("[TB] mul 0xFF*0xFF, operands zeroed while busy");
    applyStimulus(3'b100, 8'hFF, 8'hFF, 0, 1'b0, 1'b1);
    checkOutput("mul_ff_result", int'(bus.result), 'hFE01);

    $display("[TB] xor 0xF0^0x3C, start held 4 extra cycles");
    d0 = done_seen;
    applyStimulus(3'b011, 8'hF0, 8'h3C, 4, 1'b0, 1'b0);
    checkOutput("xor_result", int'(bus.result), 'h00CC);
    checkOutput("xor_pulses", done_seen - d0, 1);

    $display("[TB] add 2+3, no_op, rst_op");
    applyStimulus(3'b001, 8'h02, 8'h03, 0, 1'b0, 1'b0);
    checkOutput("add_5_result", int'(bus.result), 'h0005);
    d0 = done_seen;
    applyStimulus(3'b000, 8'h11, 8'h22, 0, 1'b0, 1'b0);
    checkOutput("noop_result", int'(bus.result), 'h0005);
    applyStimulus(3'b111, 8'h00, 8'h00, 0, 1'b0, 1'b0);
    checkOutput("rstop_result", int'(bus.result), 'h0000);
    checkOutput("noop_rstop_pulses", done_seen - d0, 0);

    $display("[TB] illegal ops then and");
    applyStimulus(3'b001, 8'h01, 8'h02, 0, 1'b0, 1'b0);
    d0 = done_seen;
    applyStimulus(3'b101, 8'h05, 8'h06, 0, 1'b0, 1'b0);
    applyStimulus(3'b110, 8'h07, 8'h08, 0, 1'b0, 1'b0);
    checkOutput("illegal_result", int'(bus.result), 'h0003);
    checkOutput("illegal_pulses", done_seen - d0, 0);
    applyStimulus(3'b010, 8'hAA, 8'h0F, 0, 1'b0, 1'b0);
    checkOutput("and_result", int'(bus.result), 'h000A);

    $display("[TB] mul with start dropped while busy");
    applyStimulus(3'b100, 8'h12, 8'h34, 0, 1'b1, 1'b0);
    checkOutput("mul_drop_result", int'(bus.result), 'h03A8);

    $display("[TB] reset one cycle after mul acceptance");
    d0 = done_seen;
    bus.start = 1'b1;
    bus.op    = 3'b100;
    bus.A     = 8'h0F;
    bus.B     = 8'h0F;
    schedule(cyc + 1 + MUL_LAT, EV_DONE, 16'h00E1);
    @(negedge clk);
    reset     = 1'b1;
    bus.start = 1'b0;
    schedule(cyc + 1, EV_RST, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("mid_mul_reset_result", int'(bus.result), 0);
    checkOutput("mid_mul_reset_pulses", done_seen - d0, 0);

    $display("[TB] reset and start on the same edge");
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.op    = 3'b001;
    bus.A     = 8'h01;
    bus.B     = 8'h01;
    schedule(cyc + 1, EV_RST, 16'h0000);
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_priority_pulses", done_seen - d0, 0);

    $display("[TB] recovery: mul 0x0F*0x0F, add 0+0");
    applyStimulus(3'b100, 8'h0F, 8'h0F, 0, 1'b0, 1'b0);
    checkOutput("mul_e1_result", int'(bus.result), 'h00E1);
    applyStimulus(3'b001, 8'h00, 8'h00, 1, 1'b0, 1'b0);
    checkOutput("add_zero_result", int'(bus.result), 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tinyalu_core.md
TINYALU_CORE -- requirements
Module: tinyalu_core

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 start  input  1  command valid; initiator holds high from command issue until done observed.
REQ-004 op  input  3  operation code, stable while start high.
REQ-005 A  input  8  operand A, unsigned, stable while start high.
REQ-006 B  input  8  operand B, unsigned, stable while start high.
REQ-007 done  output  1  one-cycle pulse; result valid in the same cycle.
REQ-008 result  output  16  operation result, held until the next done.
REQ-009 err  output  1  one-cycle pulse on acceptance of an illegal op code.
REQ-010 Parameter MUL_LAT, default 3, meaning cycles from mul acceptance to done (range 2..8).

Function
REQ-011 Op encoding SHALL be: no_op 000, add_op 001, and_op 010, xor_op 011, mul_op 100, rst_op 111; 101 and 110 illegal.
REQ-012 States SHALL be IDLE, BUSY, WAIT_LOW.
REQ-013 IDLE: start=1 on a rising edge SHALL accept the command and latch A, B, op.
REQ-014 add/and/xor accepted at edge k SHALL give done=1 in cycle k+1 (1-cycle latency); next state WAIT_LOW.
REQ-015 mul accepted at edge k SHALL go to BUSY and give done=1 in cycle k+MUL_LAT; next state WAIT_LOW.
REQ-016 add result SHALL be the 9-bit sum zero-extended to 16 bits (255+255 = 0x01FE).
REQ-017 and/xor results SHALL be the 8-bit result zero-extended to 16 bits.
REQ-018 mul result SHALL be the full 16-bit unsigned product (255*255 = 0xFE01).
REQ-019 no_op with start=1 SHALL produce no done, leave result unchanged, and keep state IDLE.
REQ-020 rst_op with start=1 SHALL clear result to 0, produce no done, and keep state IDLE.
REQ-021 Illegal op SHALL pulse err for one cycle, produce no done, leave result unchanged, and go to WAIT_LOW.
REQ-022 WAIT_LOW SHALL ignore start=1 (same command still held) and return to IDLE on the first edge with start=0.
REQ-023 A command is accepted only in IDLE; start staying high after done SHALL NOT cause a second acceptance.
REQ-024 Changes to A/B/op while BUSY SHALL NOT affect the result (latched operands used).
REQ-025 start dropping while BUSY SHALL NOT abort the operation; done still fires, then WAIT_LOW exits on the next edge.
REQ-026 done and err SHALL never be high in the same cycle, and done SHALL never be high for two consecutive cycles.

Reset
REQ-027 reset=1 SHALL force state IDLE, done=0, err=0, result=0, and clear the mul pipeline/counter.
REQ-028 reset asserted mid-mul SHALL discard the operation; no done for it after reset releases.
REQ-029 reset has priority over start in the same cycle; no command is accepted on that edge.

Structure
REQ-030 operation_t enum (codes per REQ-011) and the state enum SHALL be in the shared tinyalu package, also imported by the bench.
REQ-031 The multiplier SHALL be one sub-module, tinyalu_mul_pipe (MUL_LAT-deep, valid in/valid out); single-cycle ops SHALL be inline.

Verification
REQ-032 add A=0xFF B=0xFF, start held until done -> done exactly 1 cycle after acceptance, result=0x01FE, single done pulse.
REQ-033 mul A=0xFF B=0xFF, MUL_LAT=3 -> done 3 cycles after acceptance, result=0xFE01; A/B changed to 0 while BUSY -> result unchanged.
REQ-034 xor A=0xF0 B=0x3C, then start held 4 extra cycles after done -> result=0x00CC, exactly one done, re-accepts only after start=0.
REQ-035 rst_op after add result 0x0005 -> result=0x0000, no done; no_op -> result unchanged, no done.
REQ-036 op=101 with start -> err pulse one cycle, no done, result unchanged, next command accepted after start=0.
REQ-037 reset asserted 1 cycle after mul acceptance -> outputs 0, no done within 10 cycles after release.
